multiplier_24bit: RTL and testbench



---
 rtl/multiplier_24bit.sv | 79 +++++++
 tb/tb_multiplier_24bit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/multiplier_24bit.sv
// Sequential radix-2 shift-and-add unsigned multiplier: P = A * B over C_NUM_BITS
// enabled cycles, one (C_NUM_BITS+1)-bit adder, START/BUSY/DONE handshake.
module multiplier_24bit #(
  parameter int C_NUM_BITS = 24
) (
  input  logic                      CK,
  input  logic                      R,
  input  logic                      E,
  input  logic                      START,
  input  logic [C_NUM_BITS-1:0]     A,
  input  logic [C_NUM_BITS-1:0]     B,
  output logic                      BUSY,
  output logic                      DONE,
  output logic [2*C_NUM_BITS-1:0]   P
);

  localparam int CW = (C_NUM_BITS > 1) ? $clog2(C_NUM_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(C_NUM_BITS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state;
  logic [CW-1:0]         count;
  logic [C_NUM_BITS-1:0] mcand;
  logic [C_NUM_BITS-1:0] mplr;
  logic [C_NUM_BITS:0]   acc;

  logic [C_NUM_BITS:0]   sum;
  logic [C_NUM_BITS:0]   acc_n;
  logic [C_NUM_BITS-1:0] mplr_n;

  // The adder carry lands in sum[MSB] and is shifted down in the same cycle,
  // so acc_n's top bit is always zero and the product fits in 2*C_NUM_BITS.
  always_comb begin
    sum    = acc + {1'b0, (mplr[0] ? mcand : {C_NUM_BITS{1'b0}})};
    acc_n  = {1'b0, sum[C_NUM_BITS:1]};
    mplr_n = {sum[0], mplr[C_NUM_BITS-1:1]};
  end

  always_ff @(posedge CK or posedge R) begin
    if (R) begin
      state <= S_IDLE;
      count <= '0;
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      P     <= '0;
    end else if (E) begin
      case (state)
        S_IDLE: begin
          if (START) begin
            mcand <= B;
            mplr  <= A;
            acc   <= '0;
            count <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc   <= acc_n;
          mplr  <= mplr_n;
          count <= count + 1'b1;
          if (count == LAST) begin
            P     <= {acc_n[C_NUM_BITS-1:0], mplr_n};
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign BUSY = (state == S_RUN);
  assign DONE = (state == S_DONE);

endmodule

// File: tb/tb_multiplier_24bit.sv
// Scoreboard bench for multiplier_24bit: the driver pushes A*B on every accepted
// START, a negedge monitor pops and compares on each DONE rising edge.
module tb_multiplier_24bit;

  logic        CK = 1'b0;
  logic        R, E, START;
  logic [23:0] A, B;
  logic        BUSY, DONE;
  logic [47:0] P;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  longint exp_q[$];
  logic   done_q = 1'b0;

  multiplier_24bit #(.C_NUM_BITS(24)) dut (
    .CK(CK), .R(R), .E(E), .START(START), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .P(P)
  );

  always #5 CK = ~CK;
  always @(posedge CK) cyc++;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: one comparison per completion; a frozen DONE is one completion.
  always @(negedge CK) begin
    if (R) begin
      done_q = 1'b0;
    end else begin
      if (DONE && !done_q) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          check("product", longint'(P), exp_q.pop_front());
        end
      end
      done_q = DONE;
    end
  end

  task automatic wait_idle();
    int k = 0;
    while ((BUSY || DONE) && k < 100) begin
      @(posedge CK); #1; k++;
    end
    if (k >= 100) check("idle_timeout", k, 0);
  endtask

  // Issue one operation, optionally stalling E mid-RUN and again in DONE,
  // and check BUSY length and DONE latency in enabled-plus-stall cycles.
  task automatic run_op(input logic [23:0] a, input logic [23:0] b,
                        input int stall_at, input int stall_len, input int done_stall);
    int k = 0;
    int busy = 0;
    wait_idle();
    A = a; B = b; START = 1'b1;
    exp_q.push_back(longint'(a) * longint'(b));
    @(posedge CK); #1;
    START = 1'b0;
    A = 24'($urandom()); B = 24'($urandom());
    while (!DONE && k < 200) begin
      if (BUSY) busy++;
      E = (k >= stall_at && k < stall_at + stall_len) ? 1'b0 : 1'b1;
      @(posedge CK); #1;
      k++;
    end
    E = 1'b1;
    check("done_latency", k, 24 + stall_len);
    check("busy_cycles", busy, 24 + stall_len);
    for (int i = 0; i < done_stall; i++) begin
      E = 1'b0;
      @(posedge CK); #1;
      check("done_frozen", DONE, 1);
    end
    E = 1'b1;
  endtask

  initial begin
    int t1;
    int t2;
    int k;
    R = 1'b1; E = 1'b1; START = 1'b0; A = '0; B = '0;
    #12;
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_p", longint'(P), 0);
    @(posedge CK); #1; R = 1'b0;

    // 1: basic product, exact latency
    run_op(24'd1234, 24'd5678, -1, 0, 0);
    // 2: all ones, carry into the top bit every iteration
    run_op(24'hFFFFFF, 24'hFFFFFF, -1, 0, 0);
    // 3: zero product, then P must hold while inputs toggle
    run_op(24'd0, 24'hABCDEF, -1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge CK); #1;
      A = 24'($urandom()); B = 24'($urandom());
      check("p_hold", longint'(P), 0);
    end

    // 4: START held high; operands change during RUN
    wait_idle();
    A = 24'd4000; B = 24'd321; START = 1'b1;
    exp_q.push_back(longint'(24'd4000) * longint'(24'd321));
    @(posedge CK); #1;
    A = 24'd77; B = 24'd99;
    k = 0;
    while (!DONE && k < 100) begin @(posedge CK); #1; k++; end
    t1 = cyc;
    exp_q.push_back(longint'(24'd77) * longint'(24'd99));
    @(posedge CK); #1;
    k = 0;
    while (!DONE && k < 100) begin @(posedge CK); #1; k++; end
    t2 = cyc;
    START = 1'b0;
    check("done_spacing", t2 - t1, 26);

    // 5: stall mid-RUN for 5 cycles and in DONE for 3
    run_op(24'd3, 24'd7, 10, 5, 3);

    // 6: asynchronous reset pulse mid-operation
    wait_idle();
    A = 24'd100; B = 24'd200; START = 1'b1;
    @(posedge CK); #1; START = 1'b0;
    repeat (10) @(posedge CK);
    #2 R = 1'b1;
    #1;
    check("arst_busy", BUSY, 0);
    check("arst_done", DONE, 0);
    check("arst_p", longint'(P), 0);
    #1 R = 1'b0;
    @(posedge CK); #1;
    run_op(24'd100, 24'd200, -1, 0, 0);

    // Random operands, with occasional extremes
    for (int i = 0; i < 20; i++) begin
      logic [23:0] ra, rb;
      ra = 24'($urandom());
      rb = 24'($urandom());
      if (i % 7 == 3) ra = 24'hFFFFFF;
      if (i % 5 == 2) rb = 24'h000001;
      run_op(ra, rb, (i % 4 == 1) ? int'($urandom_range(0, 23)) : -1,
             (i % 4 == 1) ? int'($urandom_range(1, 4)) : 0, 0);
    end

    repeat (3) @(posedge CK);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
